// File: rtl/ifid_queue.sv
// ifid_queue: IF/ID packet queue, a circular buffer of {pc, instr} with flush and async active-low reset.
module ifid_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc4,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  // Empty outputs are forced so stale storage never leaks to decode.
  assign out_pc    = out_valid ? mem_pc[rd_ptr] : 32'h0;
  assign out_instr = out_valid ? mem_instr[rd_ptr] : NOP_INSTR;
  assign out_pc4   = out_valid ? out_pc + 32'd4 : 32'h0;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: directed checks of ifid_queue at DEPTH=2.
module tb_ifid_queue;
  logic        clk = 0;
  logic        reset = 0;
  logic        in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_pc4, out_instr;
  logic [1:0]  count;
  int tests = 0, fails = 0;

  ifid_queue #(.DEPTH(2), .NOP_INSTR(32'h00000000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_pc4(out_pc4), .out_instr(out_instr), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1; in_pc = pc; in_instr = instr;
    tick();
    in_valid = 0;
  endtask

  initial begin
    logic [31:0] e;
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_pc", out_pc, 0);
    check("rst_pc4", out_pc4, 0);
    check("rst_instr", out_instr, 0);
    tick();
    reset = 1;
    // fill / drain
    push(32'h0, 32'h20100005);
    check("fill1_count", 32'(count), 1);
    check("fill1_valid", 32'(out_valid), 1);
    push(32'h4, 32'h2011000C);
    check("fill2_count", 32'(count), 2);
    check("fill2_ready", 32'(in_ready), 0);
    check("fill2_pc", out_pc, 32'h0);
    check("fill2_pc4", out_pc4, 32'h4);
    check("fill2_instr", out_instr, 32'h20100005);
    out_ready = 1;
    tick();
    check("drain1_pc", out_pc, 32'h4);
    check("drain1_instr", out_instr, 32'h2011000C);
    check("drain1_count", 32'(count), 1);
    tick();
    check("drain2_valid", 32'(out_valid), 0);
    check("drain2_instr", out_instr, 32'h0);
    check("drain2_pc4", out_pc4, 32'h0);
    // full with simultaneous pop
    out_ready = 0;
    push(32'h8, 32'hA);
    push(32'hC, 32'hB);
    in_valid = 1; in_pc = 32'h10; in_instr = 32'hC; out_ready = 1;
    tick();
    in_valid = 0;
    check("fullpop_count", 32'(count), 1);
    check("fullpop_ready", 32'(in_ready), 1);
    check("fullpop_pc", out_pc, 32'hC);
    tick();
    check("fullpop_drained", 32'(count), 0);
    // streaming
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_pc = 32'(i * 4); in_instr = 32'h1000 + 32'(i);
      tick();
      check("stream_pc", out_pc, 32'(i * 4));
      check("stream_instr", out_instr, 32'h1000 + 32'(i));
      check("stream_count", 32'(count), 1);
    end
    in_valid = 0;
    tick();
    check("stream_end", 32'(count), 0);
    // flush
    out_ready = 0;
    push(32'h20, 32'h1);
    push(32'h24, 32'h2);
    in_valid = 1; in_pc = 32'h99; in_instr = 32'h3; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(out_valid), 0);
    tick();
    check("flush_nodrop_in", 32'(out_valid), 0);
    flush = 1;
    tick();
    flush = 0;
    check("flush_empty", 32'(count), 0);
    // async reset mid-cycle
    push(32'h30, 32'h5);
    push(32'h34, 32'h6);
    check("ar_pre", 32'(count), 2);
    #2 reset = 0;
    #1;
    check("ar_valid", 32'(out_valid), 0);
    check("ar_count", 32'(count), 0);
    check("ar_ready", 32'(in_ready), 1);
    tick();
    reset = 1;
    push(32'h40, 32'h7);
    check("ar_push_valid", 32'(out_valid), 1);
    check("ar_push_pc", out_pc, 32'h40);
    check("ar_push_count", 32'(count), 1);
    out_ready = 1;
    tick();
    check("ar_drain", 32'(count), 0);
    // pointer wrap with PC overflow
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      e = 32'hFFFFFFF0 + 32'(i * 4);
      in_pc = e; in_instr = ~e;
      tick();
      check("wrap_pc", out_pc, e);
      check("wrap_instr", out_instr, ~e);
      check("wrap_pc4", out_pc4, (i == 3) ? 32'h0 : e + 32'd4);
    end
    in_valid = 0;
    tick();
    check("wrap_end", 32'(count), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifid_queue.md
IFID_QUEUE -- requirements
Module: ifid_queue

Interface
REQ-001 Parameter: DEPTH, 2, number of fetch-packet entries; SHALL be a power of two, >= 2.
REQ-002 Parameter: NOP_INSTR, 32'h00000000, instruction value driven when the queue is empty.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous and active-low: asserted when 0, acts immediately, independent of clk.
REQ-005 Port: in_valid  input  1  fetch stage presents a valid PC/instruction pair.
REQ-006 Port: in_pc  input  32  PC of the presented instruction.
REQ-007 Port: in_instr  input  32  presented instruction word.
REQ-008 Port: in_ready  output  1  queue can accept a packet this cycle; fetch SHALL hold its PC when low.
REQ-009 Port: flush  input  1  branch/jump taken; discard all held packets.
REQ-010 Port: out_valid  output  1  head packet valid for decode.
REQ-011 Port: out_pc  output  32  PC of head packet.
REQ-012 Port: out_pc4  output  32  out_pc + 4, modulo 2^32.
REQ-013 Port: out_instr  output  32  instruction of head packet.
REQ-014 Port: out_ready  input  1  decode consumes head packet this cycle.
REQ-015 Port: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 Storage: circular buffer of DEPTH entries {pc[31:0], instr[31:0]}, write pointer, read pointer, occupancy counter.
REQ-017 in_ready SHALL equal (count != DEPTH); combinational from registered state only, never from out_ready.
REQ-018 Push SHALL occur when in_valid && in_ready && !flush: entry written at write pointer, pointer incremented.
REQ-019 Pop SHALL occur when out_valid && out_ready && !flush: read pointer incremented.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 count update: push only +1; pop only -1; push and pop in the same cycle, unchanged.
REQ-022 Full (count == DEPTH): in_ready 0; no push, even if a pop occurs the same cycle; no bypass path.
REQ-023 Empty (count == 0): out_valid 0, out_pc 0, out_pc4 0, out_instr NOP_INSTR; no pop; an incoming packet is not forwarded in the same cycle.
REQ-024 Latency: a packet pushed at edge N SHALL appear on outputs after edge N if the queue was empty; minimum fetch-to-decode latency is 1 cycle.
REQ-025 Non-empty: out_valid 1, out_pc/out_instr from the entry at read pointer, out_pc4 = out_pc + 4.
REQ-026 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-027 Ordering: packets SHALL leave in push order; none duplicated or dropped except by flush.
REQ-028 Flush: at the next edge, count 0 and both pointers 0; overrides any push or pop in that cycle; the in_valid packet presented during the flush cycle is discarded.
REQ-029 Flush on an empty queue SHALL have no effect beyond holding state at zero.
REQ-030 The block SHALL NOT alter instruction bits or PCs; it only stores and forwards them.

Reset
REQ-031 While reset is 0: count 0, pointers 0, out_valid 0, in_ready 1, out_pc 0, out_pc4 0, out_instr NOP_INSTR, all asynchronously.
REQ-032 Entry storage need not be cleared; contents SHALL be unobservable while empty.
REQ-033 Reset asserted mid-operation SHALL discard all held packets immediately; after release the first push behaves as from an empty queue.
REQ-034 Deassertion is synchronous to clk at system level; the first active edge after release SHALL accept a push.

Verification
REQ-035 Fill/drain: DEPTH=2, out_ready 0, push {0x0,0x20100005},{0x4,0x2011000C} -> count 2, in_ready 0, out_pc 0x0, out_pc4 0x4; raise out_ready -> 0x4/0x2011000C next, then empty with out_instr 0x00000000.
REQ-036 Full with simultaneous pop: count 2, in_valid 1, out_ready 1 -> one pop, no push, count 1, in_ready 1 after the edge.
REQ-037 Streaming: in_valid and out_ready held 1 for 8 packets, PCs 0x0..0x1C -> outputs in order, count steady at 1, each PC seen exactly once.
REQ-038 Flush: count 2 plus in_valid, flush 1 for one cycle -> count 0, out_valid 0, the presented packet never appears at the output.
REQ-039 Async reset: count 2, reset driven 0 between clock edges -> out_valid 0 and count 0 before the next edge; first push after release appears 1 cycle later.
REQ-040 Wrap: 5 push/pop pairs at DEPTH=2 -> pointers wrap, outputs stay in order, out_pc4 of PC 0xFFFFFFFC reads 0x00000000.
